// File: rtl/hdlc_tx_scheduler_if.sv
// ============================================================================
// hdlc_tx_scheduler_if : requester and Tx-core signal bundle for the scheduler
// Rev 1.0
// ============================================================================
`default_nettype none

interface hdlc_tx_scheduler_if;
  logic [1:0]      Req_Valid;
  logic [1:0][7:0] Req_Data;
  logic [1:0]      Req_Last;
  logic [1:0]      Req_Ready;
  logic [1:0]      Grant;
  logic            Tx_WrBuff;
  logic [7:0]      Tx_DataIn;
  logic            Tx_Enable;
  logic            Tx_AbortFrame;
  logic            Tx_Done;
  logic            Tx_Full;
  logic            Frame_Err;

  modport master (
    output Req_Valid, Req_Data, Req_Last, Tx_Done, Tx_Full,
    input  Req_Ready, Grant, Tx_WrBuff, Tx_DataIn, Tx_Enable, Tx_AbortFrame, Frame_Err
  );

  modport slave (
    input  Req_Valid, Req_Data, Req_Last, Tx_Done, Tx_Full,
    output Req_Ready, Grant, Tx_WrBuff, Tx_DataIn, Tx_Enable, Tx_AbortFrame, Frame_Err
  );
endinterface

`default_nettype wire

// File: rtl/hdlc_tx_scheduler.sv
// ============================================================================
// hdlc_tx_scheduler : round-robin sharing of one HDLC transmitter by two
// requesters; define HDLC_TX_SCHED_TIMEOUT_EN for the LOAD stall watchdog. Rev 1.0
// ============================================================================
`default_nettype none

module hdlc_tx_scheduler #(
  parameter int unsigned MAX_FRAME      = 126,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                Clk,
  input  logic                Rst,
  hdlc_tx_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    SEND  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] C_MAX_FRAME = 8'(MAX_FRAME);
  localparam logic [7:0] C_LAST_IDX  = 8'(MAX_FRAME - 1);

  if (MAX_FRAME < 1 || MAX_FRAME > 255 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_badParams
    $error("hdlc_tx_scheduler: MAX_FRAME or TIMEOUT_CYCLES out of range");
  end

  state_t     r_state;
  logic       r_ptr;
  logic       r_owner;
  logic       r_sawLow;
  logic [7:0] r_count;
  logic [1:0] r_grant;
  logic       r_wrBuff;
  logic [7:0] r_dataIn;
  logic       r_enable;
  logic       r_abort;
  logic       r_frameErr;

  logic [1:0] w_ready;
  logic       w_hs;
  logic       w_last;
  logic [7:0] w_data;
  logic       w_pick;
  logic       w_timeout;

  always_comb begin
    w_ready = 2'b00;
    if (r_state == LOAD && !bus.Tx_Full && r_count < C_MAX_FRAME)
      w_ready[r_owner] = 1'b1;
    else if (r_state == DRAIN)
      w_ready[r_owner] = 1'b1;
  end

  assign w_hs   = bus.Req_Valid[r_owner] & w_ready[r_owner];
  assign w_last = bus.Req_Last[r_owner];
  assign w_data = bus.Req_Data[r_owner];
  // Contention goes to the pointer; otherwise whichever requester is valid.
  assign w_pick = (&bus.Req_Valid) ? r_ptr : bus.Req_Valid[1];

`ifdef HDLC_TX_SCHED_TIMEOUT_EN
  localparam logic [15:0] C_WDOG_LIMIT = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wdog;

  assign w_timeout = (r_state == LOAD) && !w_hs && (r_wdog == C_WDOG_LIMIT);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)
      r_wdog <= 16'd0;
    else if (r_state != LOAD || w_hs || w_timeout)
      r_wdog <= 16'd0;
    else
      r_wdog <= r_wdog + 16'd1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_sawLow   <= 1'b0;
      r_count    <= 8'd0;
      r_grant    <= 2'b00;
      r_wrBuff   <= 1'b0;
      r_dataIn   <= 8'h00;
      r_enable   <= 1'b0;
      r_abort    <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      r_wrBuff   <= 1'b0;
      r_enable   <= 1'b0;
      r_abort    <= 1'b0;
      r_frameErr <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Tx_Done && |bus.Req_Valid) begin
            r_owner <= w_pick;
            r_grant <= w_pick ? 2'b10 : 2'b01;
            r_count <= 8'd0;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_hs) begin
            r_count <= r_count + 8'd1;
            if (w_last) begin
              // Final write and start pulse land in the same cycle.
              r_wrBuff <= 1'b1;
              r_dataIn <= w_data;
              r_enable <= 1'b1;
              r_state  <= START;
            end else if (r_count == C_LAST_IDX) begin
              r_abort    <= 1'b1;
              r_frameErr <= 1'b1;
              r_state    <= DRAIN;
            end else begin
              r_wrBuff <= 1'b1;
              r_dataIn <= w_data;
            end
          end else if (w_timeout) begin
            r_abort    <= 1'b1;
            r_frameErr <= 1'b1;
            r_ptr      <= ~r_owner;
            r_grant    <= 2'b00;
            r_state    <= IDLE;
          end
        end
        START: begin
          r_sawLow <= 1'b0;
          r_state  <= SEND;
        end
        SEND: begin
          // Completion means Tx_Done seen low (busy) and then high again.
          if (!bus.Tx_Done) begin
            r_sawLow <= 1'b1;
          end else if (r_sawLow) begin
            r_sawLow <= 1'b0;
            r_ptr    <= ~r_owner;
            r_grant  <= 2'b00;
            r_state  <= IDLE;
          end
        end
        DRAIN: begin
          if (w_hs && w_last) begin
            r_ptr   <= ~r_owner;
            r_grant <= 2'b00;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Req_Ready     = w_ready;
  assign bus.Grant         = r_grant;
  assign bus.Tx_WrBuff     = r_wrBuff;
  assign bus.Tx_DataIn     = r_dataIn;
  assign bus.Tx_Enable     = r_enable;
  assign bus.Tx_AbortFrame = r_abort;
  assign bus.Frame_Err     = r_frameErr;

endmodule

`default_nettype wire

// File: doc/hdlc_tx_scheduler.md
# hdlc_tx_scheduler

Round-robin scheduler that shares the single HDLC transmitter between two frame requesters. It grants one requester at a time, streams that requester's bytes into the Tx buffer, starts transmission with a one-cycle enable pulse, and holds off every other requester until the transmitter reports completion. Over-length and stalled frames are aborted cleanly, so the Tx buffer never holds a partial frame when transmission starts.

## Interface
- MAX_FRAME, 126: maximum payload bytes per frame; must be 1..255.
- TIMEOUT_CYCLES, 1024: requester stall limit in LOAD; used only when the watchdog is compiled in.

- Clk  in  1  system clock; all logic on posedge.
- Rst  in  1  reset; one clock; asynchronous and active-low.
- Req_Valid  in  2  requester i presents a byte.
- Req_Data  in  2x8  byte from requester i.
- Req_Last  in  2  byte from requester i is the final byte of its frame.
- Req_Ready  out  2  scheduler accepts requester i's byte this cycle.
- Grant  out  2  one-hot current owner; 0 when idle.
- Tx_WrBuff  out  1  write strobe to the Tx buffer.
- Tx_DataIn  out  8  byte to the Tx buffer.
- Tx_Enable  out  1  one-cycle start-transmission pulse.
- Tx_AbortFrame  out  1  one-cycle pulse; Tx core discards the buffer.
- Tx_Done  in  1  high while the Tx core is idle and its buffer is empty.
- Tx_Full  in  1  Tx buffer full.
- Frame_Err  out  1  one-cycle pulse when a frame is aborted.

## Operation
- States: IDLE, LOAD, START, SEND, DRAIN.
- Round-robin pointer `ptr` (1 bit) points to the preferred requester. Reset value 0.
- IDLE: when Tx_Done=1 and any Req_Valid is high, choose the owner. If both are valid, the owner is `ptr`; otherwise it is the one that is valid. Set Grant, clear the byte count, go to LOAD. While Tx_Done=0, no grant is issued.
- LOAD: `Req_Ready[owner] = !Tx_Full && count < MAX_FRAME`. The non-owner sees Ready=0.
  - Handshake: Valid && Ready.
  - On each handshake, Tx_WrBuff=1 and Tx_DataIn=Req_Data on the next cycle (registered), and count increments (8-bit).
  - Handshake with Req_Last=1: go to START.
  - Handshake on byte number MAX_FRAME with Req_Last=0: pulse Tx_AbortFrame and Frame_Err, then go to DRAIN.
- START: Tx_Enable=1 for exactly one cycle, then go to SEND.
- SEND: wait for Tx_Done to be sampled 0 and then 1. Then set `ptr` to the non-owner, clear Grant, and go to IDLE.
- DRAIN: `Req_Ready[owner]=1`; bytes are discarded (no Tx_WrBuff). On a handshake with Req_Last=1, rotate `ptr`, clear Grant, and go to IDLE.
- A one-byte frame (Last on the first byte) is legal.
- Reset mid-operation: all state and outputs return to reset values immediately. No Tx_Enable or Tx_AbortFrame is emitted on reset exit.
- Reset values:
  - Req_Ready=00, Grant=00, Tx_WrBuff=0, Tx_DataIn=0x00.
  - Tx_Enable=0, Tx_AbortFrame=0, Frame_Err=0.
  - State IDLE, count=0, ptr=0.

## Timing
- The grant decision is taken in IDLE. Grant is registered and goes high 1 cycle after the request.
- Req_Ready is combinational from state, count, and Tx_Full.
- Tx_WrBuff/Tx_DataIn lag the handshake by exactly 1 cycle.
- From the Last handshake: the last Tx_WrBuff is at +1 and Tx_Enable is at +1 (the same cycle). Core buffer latency must tolerate write and enable arriving in the same cycle.
- Tx_AbortFrame and Frame_Err are asserted in the cycle after the aborting handshake. No Tx_WrBuff is issued for that byte.
- Minimum gap between two frames is 2 cycles after Tx_Done rises (SEND→IDLE→LOAD).

## Configuration
- HDLC_TX_SCHED_TIMEOUT_EN defined: a 16-bit watchdog counts consecutive LOAD cycles without a handshake.
  - When it reaches TIMEOUT_CYCLES: pulse Tx_AbortFrame and Frame_Err, rotate ptr, clear Grant, go to IDLE.
  - No DRAIN is entered for a timeout.
  - The counter clears on every handshake and on leaving LOAD.
- Not defined: no watchdog; LOAD waits indefinitely.

## Test plan
- Requester 0 sends a 3-byte frame 0xA1,0xA2,0xA3 -> Tx_WrBuff pulses with those bytes in order; one Tx_Enable pulse on the cycle of the third write; Grant=01 until Tx_Done rises.
- Both requesters valid after reset -> requester 0 is served first, then requester 1 (Grant 01 then 10); a third back-to-back frame goes to requester 0.
- Requester 1 sends 127 bytes without Last, MAX_FRAME=126 -> 125 writes; Tx_AbortFrame and Frame_Err pulse once; byte 127 is accepted and discarded; no Tx_Enable.
- Tx_Full held high during LOAD -> Req_Ready=0 and no writes; the frame resumes correctly when Tx_Full drops.
- Rst low during SEND -> all outputs 0 within the reset; after release, a new request is granted to requester 0.
- With HDLC_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16: requester stalls after 2 bytes -> Tx_AbortFrame 16 cycles after the last handshake; Grant returns to 00.
